// File: rtl/attn_core_scheduler_pkg.sv
// attn_core_scheduler_pkg: shared attention widths and scheduler types
package attn_core_scheduler_pkg;
    localparam int att_width     = 16;
    localparam int HW            = 4;
    localparam int SCHED_NUM_REQ = 4;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} sched_state_t;
endpackage

// File: rtl/attn_core_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting just after the last winner
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] rr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);
    localparam int IW = $clog2(N);
    always_comb begin
        idx_o = '0;
        // scan farthest offset first so the nearest requester overwrites
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(rr_i) + k) % N]) idx_o = IW'((int'(rr_i) + k) % N);
        end
    end
    assign valid_o = |req_i;
    assign gnt_o   = N'(valid_o) << idx_o;
endmodule

// File: rtl/attn_core_scheduler.sv
// attn_core_scheduler: shares one attention core between NUM_REQ heads, round-robin,
// one job per grant with a flush gap so the core's internal counters clear.
module attn_core_scheduler
    import attn_core_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = SCHED_NUM_REQ,
    parameter int TIMEOUT   = 64,
    parameter int FLUSH_CYC = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*att_width-1:0]   req_att_i,
    input  logic [NUM_REQ*att_width-1:0]   req_bias_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [NUM_REQ-1:0]             done_o,
    output logic [att_width-1:0]           result_o,
    output logic                           timeout_err_o,
    output logic                           busy_o,
    output logic                           core_en_o,
    output logic [att_width-1:0]           core_i_att_o,
    output logic [att_width-1:0]           core_att_bias_o,
    input  logic                           core_end_flag_i,
    input  logic [att_width-1:0]           core_o_att_i
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int RW = $clog2(TIMEOUT);
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam logic [RW-1:0] RUN_LAST   = RW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
    sched_state_t         state_q;
    logic [IW-1:0]        rr_q, widx_q, widx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d, done_q;
    logic [att_width-1:0] result_q;
    logic [RW-1:0]        run_cnt_q;
    logic [FW-1:0]        flush_cnt_q;
    logic                 timeout_q, busy_q, en_q, win_valid;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i   (req_i),
        .rr_i    (rr_q),
        .gnt_o   (grant_d),
        .idx_o   (widx_d),
        .valid_o (win_valid)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= IW'(NUM_REQ - 1);
            widx_q      <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            en_q        <= 1'b0;
            run_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            done_q    <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: if (win_valid) begin
                    state_q   <= RUN;
                    grant_q   <= grant_d;
                    widx_q    <= widx_d;
                    rr_q      <= widx_d;
                    en_q      <= 1'b1;
                    busy_q    <= 1'b1;
                    run_cnt_q <= '0;
                end
                RUN: if (core_end_flag_i || run_cnt_q == RUN_LAST) begin
                    state_q     <= FLUSH;
                    grant_q     <= '0;
                    en_q        <= 1'b0;
                    flush_cnt_q <= '0;
                    // end_flag beats a coincident timeout
                    if (core_end_flag_i) begin
                        result_q <= core_o_att_i;
                        done_q   <= grant_q;
                    end else begin
                        timeout_q <= 1'b1;
                    end
                end else begin
                    run_cnt_q <= run_cnt_q + 1'b1;
                end
                FLUSH: if (flush_cnt_q == FLUSH_LAST) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    flush_cnt_q <= flush_cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign grant_o         = grant_q;
    assign done_o          = done_q;
    assign result_o        = result_q;
    assign timeout_err_o   = timeout_q;
    assign busy_o          = busy_q;
    assign core_en_o       = en_q;
    assign core_i_att_o    = |grant_q ? req_att_i[widx_q*att_width +: att_width] : '0;
    assign core_att_bias_o = |grant_q ? req_bias_i[widx_q*att_width +: att_width] : '0;
endmodule

// File: doc/attn_core_scheduler.md
Name: attn_core_scheduler

Overview:
- Round-robin scheduler that shares one Attention_core instance between NUM_REQ requesters (attention heads).
- Arbitrates requests and muxes the granted requester's activation/bias stream onto the core.
- Holds core enable for one job, captures the result on core end_flag, then drops enable so the core's internal counters clear before the next job.
- Sits between the head-level control and the single attention datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 64, max cycles in RUN before a job is aborted (>=8)
- FLUSH_CYC, 2, cycles core enable is held low between jobs (>=1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester job request (level)
- req_att  in  NUM_REQ*att_width  packed per-requester activation stream, slice i = requester i
- req_bias  in  NUM_REQ*att_width  packed per-requester bias stream
- grant  out  NUM_REQ  one-hot grant, held for whole job
- done  out  NUM_REQ  one-cycle pulse to owner on successful completion
- result  out  att_width  last captured core output
- timeout_err  out  1  one-cycle pulse on aborted job
- busy  out  1  high in RUN and FLUSH
- core_en  out  1  to core en
- core_i_att  out  att_width  to core i_att
- core_att_bias  out  att_width  to core att_bias
- core_end_flag  in  1  from core end_flag
- core_o_att  in  att_width  from core o_att

Behaviour:
- Reset values: grant=0, done=0, result=0, timeout_err=0, busy=0, core_en=0, state=IDLE, rr pointer=NUM_REQ-1 (requester 0 has first priority), run counter=0, flush counter=0.
- All outputs are registered except core_i_att and core_att_bias. Those are a combinational mux of req_att/req_bias by the grant index; they are 0 when grant==0.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - Search req starting at rr+1, wrapping modulo NUM_REQ; the first set bit wins.
  - If any req is set at cycle t: at t+1, grant is one-hot on the winner, rr=winner, core_en=1, busy=1, run counter=0, state=RUN.
  - If no req is set, stay in IDLE.
- RUN:
  - Run counter increments each cycle.
  - req is not resampled: dropping req mid-job does not abort the job, and new requests wait.
  - core_end_flag=1 at cycle t: at t+1, result=core_o_att (sampled at t), done[winner]=1 for one cycle, core_en=0, grant=0, state=FLUSH.
  - Run counter reaches TIMEOUT-1 with no end_flag: at next cycle, timeout_err=1 for one cycle, done stays 0, result unchanged, core_en=0, grant=0, state=FLUSH.
  - end_flag and timeout in the same cycle: end_flag wins (normal completion, no error).
- FLUSH:
  - core_en stays 0 for exactly FLUSH_CYC cycles, then state=IDLE and busy=0.
  - core_end_flag is ignored in FLUSH and IDLE.
- Back-to-back jobs: with a request pending, the gap between core_en falling and rising again is FLUSH_CYC+1 cycles (FLUSH cycles plus one arbitration cycle).
- Fairness: a requester holding req continuously is granted at least once every NUM_REQ jobs.
- Reset mid-job: all outputs go to reset values immediately (asynchronously); the core sees en=0; no done or timeout_err is emitted.
- Widths: the run counter is clog2(TIMEOUT) bits; the flush counter is clog2(FLUSH_CYC+1) bits; the winner index is clog2(NUM_REQ) bits.

Decomposition:
- att_width and HW come from the shared definition package.
- Add to that package:
  - typedef enum sched_state_t {IDLE, RUN, FLUSH};
  - constant SCHED_NUM_REQ=4.
- One sub-module, rr_arbiter: combinational round-robin winner search with inputs req and rr pointer and a one-hot plus index output. It is reusable for later shared PEs.

Test Plan:
- Single request: req=4'b0010, core returns end_flag 10 cycles after core_en with o_att=16'h0035 -> grant=0010 one cycle after req; done=0010 pulse and result=0035 one cycle after end_flag; core_en low for 2 cycles; busy falls after FLUSH.
- All requesting: req=4'b1111 held for 8 jobs -> grant order 0,1,2,3,0,1,2,3; core_i_att matches the granted slice every RUN cycle.
- Timeout: end_flag never asserted -> timeout_err pulse exactly 64 cycles after RUN entry; done stays 0; result unchanged; next requester granted after flush.
- Simultaneous end_flag and timeout: end_flag on run count 63 -> done pulses, timeout_err stays 0.
- Mid-job req drop and late arrival: requester 1 drops req during RUN and requester 3 raises req -> job 1 completes normally with done[1]; requester 3 is granted next.
- Reset mid-RUN: rstn low for 1 cycle during RUN -> core_en, grant and busy go to 0 immediately; no done; after release, requester 0 has priority.
